confirm_input_sync: RTL
=======================

Name: confirm_input_sync

Overview:
- Upstream input stage for the board-level CPU top. Consumes the raw confirm push-button, the 8 data switches and the 3 test-select switches.
- Produces a debounced, held confirm flag (feeds the CPU ConfirmCtrl input), a latched test_index and a latched switch snapshot (feeds the io_rdata path).
- The snapshot is taken once per accepted press and held until the CPU acknowledges the read. Switch data therefore cannot change under a running test.

Parameters:
- DB_CYCLES, 200000, number of consecutive stable synchronised samples required to accept a press or a release (2 ms at 100 MHz). Must be at least 2.
- CNT_W, 18, counter width. Must satisfy 2^CNT_W > DB_CYCLES-1.
- SW_W, 8, data switch width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_confirm_raw  in  1  unsynchronised confirm button, high = pressed.
- sw_raw  in  SW_W  unsynchronised data switches.
- test_sel_raw  in  3  unsynchronised test-select switches.
- cpu_ack  in  1  one-cycle pulse from the CPU IO read path: the confirmed data has been consumed.
- confirm  out  1  held high from an accepted press until cpu_ack (to ConfirmCtrl).
- test_index  out  3  test select latched at the accepted press.
- sw_data  out  SW_W  switch snapshot latched at the accepted press.
- dropped  out  1  sticky: a press was accepted while confirm was already high.

Behaviour:
- Reset (async, rst=1): confirm=0, test_index=0, sw_data=0, dropped=0, state=IDLE, cnt=0, synchroniser flops=0.
- Synchronisation:
  - Every raw input passes through a 2-flop synchroniser (s1 then s2).
  - All logic uses the s2 values only.
- FSM state IDLE (waiting for a press):
  - btn_s2=0: cnt<=0.
  - btn_s2=1 and cnt!=DB_CYCLES-1: cnt<=cnt+1.
  - btn_s2=1 and cnt==DB_CYCLES-1: ACCEPT event; cnt<=0; state<=HELD.
- FSM state HELD (waiting for a release):
  - btn_s2=1: cnt<=0.
  - btn_s2=0 and cnt!=DB_CYCLES-1: cnt<=cnt+1.
  - btn_s2=0 and cnt==DB_CYCLES-1: cnt<=0; state<=IDLE.
- Press latency:
  - Raw input high and stable from sampling edge k gives confirm=1 after edge k+DB_CYCLES+1.
  - A glitch shorter than DB_CYCLES samples never produces ACCEPT.
  - A held button produces exactly one ACCEPT.
  - A new ACCEPT requires a debounced release first.
- ACCEPT with confirm=0: confirm<=1; test_index<=test_sel_s2; sw_data<=sw_s2.
- ACCEPT with confirm=1 and cpu_ack=0:
  - test_index and sw_data are unchanged.
  - confirm stays 1.
  - dropped<=1.
- ACCEPT and cpu_ack on the same edge:
  - The new press wins: confirm stays 1; test_index and sw_data take the new values.
  - dropped is not set.
- cpu_ack with no ACCEPT: confirm<=0; dropped<=0.
- cpu_ack while confirm=0: no effect.
- test_index and sw_data hold their values after cpu_ack until the next ACCEPT.
- Reset asserted mid-debounce or while confirm=1: all state is cleared immediately.
- After reset release with the button still held:
  - The press is treated as a new press.
  - ACCEPT occurs after DB_CYCLES stable samples.
- Counter width: cnt never exceeds DB_CYCLES-1, so there is no wrap.

Test Plan (DB_CYCLES=4 for simulation):
1. Clean press: rst pulse, sw_raw=8'hA5, test_sel_raw=3'd5, button high from edge 0 and held -> confirm rises after edge 5, sw_data=8'hA5, test_index=5. Button held 50 cycles -> no second ACCEPT. cpu_ack pulse -> confirm=0, sw_data still 8'hA5.
2. Bounce rejection: button high 3 cycles, low 1, high 2, low -> confirm stays 0, state IDLE. Then stable high -> confirm after 4 stable synchronised samples.
3. Press while pending: accept with sw=8'h11; release 6 cycles; sw=8'h22; press again without ack -> sw_data=8'h11, dropped=1. cpu_ack -> confirm=0, dropped=0.
4. Simultaneous ACCEPT and cpu_ack: pending data 8'h11; align cpu_ack with the second ACCEPT edge, sw=8'h33 -> confirm=1, sw_data=8'h33, dropped=0.
5. Async reset mid-operation: confirm=1, dropped=1; assert rst between clock edges -> all outputs 0 before the next edge. Release rst with button held -> ACCEPT 4 synchronised samples later.
6. Switch change after latch: accept with test_sel=3'd2; change test_sel_raw to 3'd7 without a new press -> test_index stays 2.

Source files
------------

// File: rtl/confirm_input_sync.sv
// Confirm push-button front end: synchronises the raw button and switches, debounces
// press and release, and holds a confirm flag with a switch snapshot until the CPU acks.
module confirm_input_sync #(
    parameter int DB_CYCLES = 200000,
    parameter int CNT_W     = 18,
    parameter int SW_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_confirm_raw,
    input  logic [SW_W-1:0] sw_raw,
    input  logic [2:0]      test_sel_raw,
    input  logic            cpu_ack,
    output logic            confirm,
    output logic [2:0]      test_index,
    output logic [SW_W-1:0] sw_data,
    output logic            dropped
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic            btn_s1, btn_s2;
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic [2:0]      sel_s1, sel_s2;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic            accept;

    // Two-flop synchronisers; nothing downstream looks at the s1 stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            btn_s1 <= btn_confirm_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
            sel_s1 <= test_sel_raw;
            sel_s2 <= sel_s1;
        end
    end

    // A press is accepted on the DB_CYCLES-th consecutive high sample seen in IDLE.
    assign accept = (state == IDLE) && btn_s2 && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!btn_s2) begin
                        cnt <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (btn_s2) begin
                        cnt <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A new press arriving with the ack replaces the consumed data rather than being dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            confirm    <= 1'b0;
            test_index <= '0;
            sw_data    <= '0;
            dropped    <= 1'b0;
        end else if (accept) begin
            if (!confirm || cpu_ack) begin
                confirm    <= 1'b1;
                test_index <= sel_s2;
                sw_data    <= sw_s2;
            end else begin
                dropped <= 1'b1;
            end
        end else if (cpu_ack && confirm) begin
            confirm <= 1'b0;
            dropped <= 1'b0;
        end
    end

endmodule
